// File: rtl/uart_tx_buf.sv
// UART transmitter with a byte FIFO front end: never stalls the writer, drops on full (sticky overflow).
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1); default build sends 8N1.
module uart_tx_buf #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrreq,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   PTR_ONE   = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                push, pop;
  logic [7:0]          head;

  // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign push  = wrreq && !full;
  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)          wr_ptr   <= wr_ptr + PTR_ONE;
      if (pop)           rd_ptr   <= rd_ptr + PTR_ONE;
      if (wrreq && full) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- serializer
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);
  assign busy      = (state_q != IDLE);
  assign tx        = tx_q;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: if (baud_last) begin
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (baud_last) begin
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = parity_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_last) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (baud_last) begin
        // Back-to-back: pop on the last stop cycle so the next start bit follows immediately.
        if (!empty) begin
          pop     = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (pop) begin
      shift_d = head;
      bit_d   = 3'd0;
      baud_d  = '0;
    end
`ifdef UART_TX_PARITY_EN
    parity_d = pop ? ^head : parity_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
